// File: rtl/nn_input_packer.sv
// nn_input_packer: collects a narrow feature stream into N_ELEM-wide frames.
// There are two frame slots used as a ping-pong buffer, so the next frame can
// fill while the core still holds the current one. Short frames are zero-padded
// and set err_short. Long frames are truncated to N_ELEM features, set err_long,
// and the rest of the stream is dropped up to the next s_last.
module nn_input_packer #(
  parameter int ELEM_W = 18,
  parameter int N_ELEM = 10,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ELEM_W-1:0]        s_dat,
  input  logic                     s_vld,
  input  logic                     s_last,
  output logic                     s_rdy,
  output logic [N_ELEM*ELEM_W-1:0] m_dat,
  output logic                     m_vld,
  input  logic                     m_rdy,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic                     err_short,
  output logic                     err_long
);

  localparam int FRAME_W = N_ELEM * ELEM_W;
  localparam int IDX_W   = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

  typedef enum logic {
    FILL,
    DROP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_sel_q, wr_sel_d;
  logic                 rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   slot_q [2];
  logic [FRAME_W-1:0]   slot_d [2];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_s_q, err_s_d;
  logic                 err_l_q, err_l_d;

  logic s_acc;
  logic m_hs;

  // Handshake qualifiers. s_rdy is forced low while reset is held.
  always_comb begin
    s_rdy = !reset && ((state_q == DROP) || !full_q[wr_sel_q]);
    s_acc = s_vld && s_rdy;
    m_hs  = full_q[rd_sel_q] && m_rdy;
  end

  // Next-state logic. The input side and the output side update independently.
  // When both act in the same cycle they always target different slots, because
  // a close needs an empty write slot and a handshake needs a full read slot.
  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    cnt_d    = cnt_q;
    err_s_d  = err_s_q;
    err_l_d  = err_l_q;

    if (m_hs) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
      cnt_d            = cnt_q + 1'b1;
    end

    if (s_acc) begin
      unique case (state_q)
        FILL: begin
          // Clear the slot on the first write so a short frame reads zero-padded.
          if (idx_q == '0) begin
            slot_d[wr_sel_q] = '0;
          end
          slot_d[wr_sel_q][idx_q*ELEM_W +: ELEM_W] = s_dat;
          if (s_last || (idx_q == IDX_LAST)) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
            idx_d            = '0;
            if (!s_last) begin
              err_l_d = 1'b1;
              state_d = DROP;
            end else if (idx_q != IDX_LAST) begin
              err_s_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DROP: begin
          if (s_last) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      idx_q    <= '0;
      slot_q   <= '{default: '0};
      cnt_q    <= '0;
      err_s_q  <= 1'b0;
      err_l_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      err_s_q  <= err_s_d;
      err_l_q  <= err_l_d;
    end
  end

  // The output side is driven only from registers.
  always_comb begin
    m_vld     = full_q[rd_sel_q];
    m_dat     = slot_q[rd_sel_q];
    frame_cnt = cnt_q;
    err_short = err_s_q;
    err_long  = err_l_q;
  end

endmodule

// File: tb/tb_nn_input_packer.sv
// Testbench for nn_input_packer. A feature queue drives the input stream, and a
// frame-level reference model predicts each delivered frame, the ready/valid
// levels, the frame count and the error flags.
module tb_nn_input_packer;

  localparam int ELEM_W  = 18;
  localparam int N_ELEM  = 10;
  localparam int CNT_W   = 16;
  localparam int FRAME_W = N_ELEM * ELEM_W;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [ELEM_W-1:0]  s_dat = '0;
  logic               s_vld = 1'b0;
  logic               s_last = 1'b0;
  logic               s_rdy;
  logic [FRAME_W-1:0] m_dat;
  logic               m_vld;
  logic               m_rdy = 1'b0;
  logic [CNT_W-1:0]   frame_cnt;
  logic               err_short;
  logic               err_long;

  nn_input_packer #(
    .ELEM_W(ELEM_W),
    .N_ELEM(N_ELEM),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_dat    (s_dat),
    .s_vld    (s_vld),
    .s_last   (s_last),
    .s_rdy    (s_rdy),
    .m_dat    (m_dat),
    .m_vld    (m_vld),
    .m_rdy    (m_rdy),
    .frame_cnt(frame_cnt),
    .err_short(err_short),
    .err_long (err_long)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ELEM_W-1:0] dat;
    logic              last;
  } feat_t;

  feat_t              feat_q[$];
  logic [FRAME_W-1:0] exp_q[$];

  // Reference model state
  logic [FRAME_W-1:0] cur;
  int                 cnt;
  bit                 drop;
  bit                 es;
  bit                 el;
  logic [CNT_W-1:0]   delivered;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  bit tog   = 1'b0;

  task automatic check(input string tag, input logic [FRAME_W-1:0] obs,
                       input logic [FRAME_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    cur       = '0;
    cnt       = 0;
    drop      = 1'b0;
    es        = 1'b0;
    el        = 1'b0;
    delivered = '0;
    feat_q.delete();
    exp_q.delete();
  endtask

  // Model one accepted feature: either build up the current frame or discard
  // the feature while dropping.
  task automatic model_feed(input feat_t f);
    if (drop) begin
      if (f.last) drop = 1'b0;
    end else begin
      cur[cnt*ELEM_W +: ELEM_W] = f.dat;
      cnt++;
      if (f.last || cnt == N_ELEM) begin
        exp_q.push_back(cur);
        if (f.last && cnt < N_ELEM) es = 1'b1;
        if (!f.last) begin
          el   = 1'b1;
          drop = 1'b1;
        end
        cur = '0;
        cnt = 0;
      end
    end
  endtask

  task automatic push(input logic [ELEM_W-1:0] d, input logic l);
    feat_t f;
    f.dat  = d;
    f.last = l;
    feat_q.push_back(f);
  endtask

  // One clock cycle. m_rdy mode: 0 low, 1 high, 2 toggling, 3 random.
  // Mode 3 also inserts random gaps in s_vld.
  task automatic cycle(input int mode);
    bit exp_srdy, exp_mvld, in_hs, out_hs, allow;
    feat_t f;
    allow = (mode != 3) || ($urandom_range(0, 3) != 0);
    case (mode)
      0:       m_rdy = 1'b0;
      1:       m_rdy = 1'b1;
      2:       begin tog = ~tog; m_rdy = tog; end
      default: m_rdy = 1'($urandom_range(0, 1));
    endcase
    if (allow && feat_q.size() > 0) begin
      f      = feat_q[0];
      s_vld  = 1'b1;
      s_dat  = f.dat;
      s_last = f.last;
    end else begin
      s_vld  = 1'b0;
      s_dat  = ELEM_W'($urandom);
      s_last = 1'($urandom_range(0, 1));
    end
    #1;
    exp_srdy = drop || (exp_q.size() < 2);
    exp_mvld = exp_q.size() > 0;
    check("s_rdy", FRAME_W'(s_rdy), FRAME_W'(exp_srdy));
    check("m_vld", FRAME_W'(m_vld), FRAME_W'(exp_mvld));
    if (exp_mvld) check("m_dat", m_dat, exp_q[0]);
    check("frame_cnt", FRAME_W'(frame_cnt), FRAME_W'(delivered));
    check("err_short", FRAME_W'(err_short), FRAME_W'(es));
    check("err_long", FRAME_W'(err_long), FRAME_W'(el));
    in_hs  = s_vld && exp_srdy;
    out_hs = exp_mvld && m_rdy;
    @(posedge clk);
    if (out_hs) begin
      void'(exp_q.pop_front());
      delivered = delivered + 1'b1;
    end
    if (in_hs) begin
      f = feat_q.pop_front();
      model_feed(f);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic drain(input int mode);
    int k = 0;
    while ((feat_q.size() > 0 || exp_q.size() > 0) && k < 2000) begin
      cycle(mode);
      k++;
    end
    check("drain_pending", FRAME_W'(feat_q.size() + exp_q.size()), '0);
    repeat (3) cycle(mode);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_vld = 1'b0;
    m_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_rdy", FRAME_W'(s_rdy), '0);
    check("rst_m_vld", FRAME_W'(m_vld), '0);
    check("rst_m_dat", m_dat, '0);
    check("rst_frame_cnt", FRAME_W'(frame_cnt), '0);
    check("rst_err_short", FRAME_W'(err_short), '0);
    check("rst_err_long", FRAME_W'(err_long), '0);
    model_clear();
    reset = 1'b0;
  endtask

  initial begin
    model_clear();

    // Reset state
    do_reset();

    // Basic frame: 1..10, s_last on the 10th
    for (int i = 1; i <= N_ELEM; i++) push(ELEM_W'(i), i == N_ELEM);
    drain(1);

    // Backpressure: three frames with m_rdy held low, then release
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N_ELEM; i++) push(ELEM_W'($urandom), i == N_ELEM - 1);
    n_acc = 0;
    repeat (40) cycle(0);
    check("bp_accepts", FRAME_W'(n_acc), FRAME_W'(20));
    drain(1);

    // Short frame: four features of all ones
    for (int i = 0; i < 4; i++) push('1, i == 3);
    drain(1);

    // Long frame: 1..13, s_last only on 13, then one normal frame
    for (int i = 1; i <= 13; i++) push(ELEM_W'(i), i == 13);
    for (int i = 0; i < N_ELEM; i++) push(ELEM_W'($urandom), i == N_ELEM - 1);
    drain(1);

    // Overlapping handshakes: m_rdy toggles every cycle over five frames
    for (int f = 0; f < 5; f++)
      for (int i = 0; i < N_ELEM; i++) push(ELEM_W'($urandom), i == N_ELEM - 1);
    drain(2);

    // Mid-frame reset after six features, then a clean frame
    for (int i = 0; i < 6; i++) push(ELEM_W'($urandom), 1'b0);
    repeat (6) cycle(1);
    do_reset();
    for (int i = 0; i < N_ELEM; i++) push(ELEM_W'($urandom), i == N_ELEM - 1);
    drain(1);

    // Random frame lengths with random gaps and random backpressure
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, 13);
      for (int i = 0; i < len; i++) push(ELEM_W'($urandom), i == len - 1);
    end
    drain(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
